cam_array_ctrl: RTL and testbench
=================================

// Module: cam_array_ctrl
// PURPOSE
//  Initiator-side sequencer for the 4-bit 9T-SRAM CAM word.
//  Turns one-at-a-time write/read/search requests into cell-level strobes:
//   - write: WLWR, DL/DLB
//   - read:  per-bit RWL, RBL precharge
//   - search: CAMDATA
//  Samples the array returns RBL and MATCH, and hands back a registered response.
//  Sits between the mobile-SoC bus adapter and the CAM cell array.
// PARAMETERS
//  WIDTH     4  bits per CAM word (one RWL per bit, shared RBL)
//  WR_PULSE  2  cycles WLWR held high (>=1)
//  SR_SETTLE 2  cycles CAMDATA driven before MATCH sampled (>=1)
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  req_valid  in   1      request present
//  req_ready  out  1      controller idle and accepting
//  req_op     in   2      00 write, 01 read, 10 search, 11 illegal
//  req_data   in   WIDTH  write data / search key
//  rsp_valid  out  1      response held until rsp_ready
//  rsp_ready  in   1      response consumed
//  rsp_data   out  WIDTH  read data (write/search: echo of req_data)
//  rsp_hit    out  1      search hit (stored word == key)
//  rsp_err    out  1      illegal op (or verify mismatch, see CONFIGURATION)
//  wlwr       out  1      write wordline
//  dl / dlb   out  WIDTH  write bitlines; dlb == ~dl whenever wlwr=1
//  rbl_pre    out  1      RBL precharge enable (RBL high when asserted)
//  rwl        out  WIDTH  one-hot read wordlines
//  rbl_in     in   1      read bitline; low = stored 0, high = stored 1
//  camdata    out  WIDTH  search key to cells
//  match_in   in   1      array MATCH; 1 = at least one bit mismatches
// BEHAVIOUR
//  Reset values: all outputs 0, except req_ready=1 and dlb all-ones.
//  Reset is effective immediately, including mid-operation:
//   - any strobe (wlwr, rwl, rbl_pre) drops asynchronously;
//   - the in-flight request is discarded with no response.
//  Handshake:
//   - Request accepted on clk when req_valid & req_ready; req_ready=0 until response consumed.
//   - Response delivered: rsp_valid=1 with stable rsp_* until rsp_valid & rsp_ready.
//   - req_ready returns to 1 in the cycle after the response is consumed (no overlap).
//  Outputs are driven from registers; no combinational path from an input to an output.
//  FSM states: IDLE, WR_SET, WR_PULSE, WR_HOLD, RD_PRE, RD_EVAL, SR_DRV, RESP.
//  IDLE: on accept, latch op and data, then go by op:
//   - write -> WR_SET
//   - read -> RD_PRE (bit index 0)
//   - search -> SR_DRV
//   - illegal -> RESP with rsp_err=1
//  Write:
//   - WR_SET (1 cycle): drive dl=data, dlb=~data, wlwr=0.
//   - WR_PULSE (WR_PULSE cycles): wlwr=1.
//   - WR_HOLD (1 cycle): wlwr=0, dl/dlb stable.
//   - Then RESP.
//  Read, for bit i = 0..WIDTH-1:
//   - RD_PRE (1 cycle): rbl_pre=1, rwl=0.
//   - RD_EVAL (1 cycle): rbl_pre=0, rwl=1<<i; rbl_in sampled into rsp_data[i] at cycle end.
//   - After bit WIDTH-1 -> RESP.
//  Search:
//   - SR_DRV (SR_SETTLE cycles): camdata=key.
//   - On the last cycle, rsp_hit = ~match_in; then RESP.
//  camdata stays at the last key after search; it is reset to 0 only by rst_n.
//  Latency, accept edge to rsp_valid=1 (WIDTH=4 defaults):
//   - write: WR_PULSE+2 = 4 cycles
//   - read: 2*WIDTH = 8 cycles
//   - search: SR_SETTLE = 2 cycles
//   - illegal op: 1 cycle
//  Never: rwl and wlwr high together; more than one rwl bit high; rbl_pre high together with rwl.
//  A response held by rsp_ready=0 stalls indefinitely; no timeout.
//  rsp_valid=1 and rsp_ready=1 in the same cycle as a new req_valid: the request is not accepted that cycle.
// CONFIGURATION
//  CAM_WR_VERIFY_EN defined:
//   - after WR_HOLD, run a full read sequence (RD_PRE/RD_EVAL x WIDTH);
//   - rsp_data = read-back value; rsp_err = (read-back != written);
//   - write latency becomes WR_PULSE+2+2*WIDTH.
//  Not defined: write goes WR_HOLD -> RESP; rsp_err covers only illegal ops.
// STRUCTURE
//  cam_pkg holds:
//   - op encoding localparams (OP_WR, OP_RD, OP_SR, OP_ILL);
//   - FSM state encoding;
//   - default timing constants.
//  Sub-module cam_rd_seq: bit-serial precharge/evaluate sequencer with start/done.
//   - Instantiated once; reused by read and by the write-verify option.
// TESTING
//  1 Reset: rst_n=0 -> req_ready=1, wlwr=0, rwl=0, rbl_pre=0, dlb=4'hF, rsp_valid=0.
//  2 Write 4'hA -> dl=A, dlb=5; wlwr high exactly 2 cycles; rsp_valid on 4th cycle after accept, rsp_err=0.
//  3 Read, model returns rbl_in per stored 4'hA -> rwl walks 1,2,4,8 with a precharge cycle before each; rsp_data=A at cycle 8.
//  4 Search key 4'hA vs stored A (match_in=0) -> rsp_hit=1 at cycle 2; key 4'h3 (match_in=1) -> rsp_hit=0.
//  5 op=11 -> rsp_err=1 next cycle; hold rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0 throughout.
//  6 rst_n low during RD_EVAL of bit 2 -> rwl=0 immediately, no response; next write completes normally.

Source files
------------

// File: rtl/cam_pkg.sv
// cam_pkg
//   Shared definitions for the 4-bit 9T-SRAM CAM word controller:
//   request opcode encoding, controller FSM state encoding and the
//   default timing constants used as parameter defaults.
//   Optional feature macro used by the controller: CAM_WR_VERIFY_EN.
package cam_pkg;

    // Default geometry and timing.
    localparam int CAM_WIDTH     = 4;
    localparam int CAM_WR_PULSE  = 2;
    localparam int CAM_SR_SETTLE = 2;

    // Width of the shared pulse/settle cycle counter.
    localparam int CAM_CNT_W     = 4;

    // Request opcodes.
    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_SR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    // Controller states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SET,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_RD_PRE,
        ST_RD_EVAL,
        ST_SR_DRV,
        ST_RESP
    } cam_state_e;

endpackage

// File: rtl/cam_rd_seq.sv
// cam_rd_seq
//   Bit-serial read sequencer for one CAM word. For each bit i it spends
//   one cycle precharging the shared read bitline, then one cycle with
//   read wordline i raised; the bitline is captured into bit i at the end
//   of that evaluate cycle.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a sequence at bit 0 (one-cycle pulse)
//   rbl_in     : read bitline from the array (high = stored 1)
//   rbl_pre    : registered precharge enable
//   rwl        : registered one-hot read wordlines
//   done       : high during the evaluate cycle of the last bit
//   data       : captured word, with the live bitline merged into the
//                bit currently being evaluated (valid when done=1)
module cam_rd_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             rbl_in,
    output logic             rbl_pre,
    output logic [WIDTH-1:0] rwl,
    output logic             done,
    output logic [WIDTH-1:0] data
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             busy;
    logic             eval;
    logic [BIT_W-1:0] bit_idx;
    logic [WIDTH-1:0] captured;
    logic             last_bit;

    assign last_bit = (bit_idx == BIT_W'(WIDTH - 1));
    assign done     = busy & eval & last_bit;

    // The bit under evaluation is taken straight from the bitline so the
    // caller can register the complete word on the same edge as done.
    always_comb begin
        data          = captured;
        data[bit_idx] = rbl_in;
    end

    // Precharge and wordline are never both high: each evaluate cycle
    // drops precharge, and each precharge cycle clears the wordlines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            eval     <= 1'b0;
            bit_idx  <= '0;
            captured <= '0;
            rbl_pre  <= 1'b0;
            rwl      <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            eval    <= 1'b0;
            bit_idx <= '0;
            rbl_pre <= 1'b1;
            rwl     <= '0;
        end else if (busy) begin
            if (!eval) begin
                eval    <= 1'b1;
                rbl_pre <= 1'b0;
                rwl     <= WIDTH'(1) << bit_idx;
            end else begin
                captured <= data;
                eval     <= 1'b0;
                rwl      <= '0;
                if (last_bit) begin
                    busy <= 1'b0;
                end else begin
                    bit_idx <= bit_idx + BIT_W'(1);
                    rbl_pre <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cam_array_ctrl.sv
// cam_array_ctrl
//   Initiator-side sequencer for a 9T-SRAM CAM word. Accepts one
//   write/read/search request at a time, turns it into cell strobes and
//   returns a registered response held until consumed.
//   Optional feature: define CAM_WR_VERIFY_EN to follow every write with a
//   full read-back; the response then carries the read-back word and
//   flags an error when it differs from the written word.
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake
//   req_op, req_data     : opcode (00 wr, 01 rd, 10 search, 11 illegal), data/key
//   rsp_valid/rsp_ready  : response handshake
//   rsp_data/hit/err     : read data or echo, search hit, error
//   wlwr, dl, dlb        : write wordline and bitlines
//   rbl_pre, rwl, rbl_in : read precharge, read wordlines, read bitline
//   camdata, match_in    : search key to cells, array mismatch return
module cam_array_ctrl
    import cam_pkg::*;
#(
    parameter int WIDTH     = CAM_WIDTH,
    parameter int WR_PULSE  = CAM_WR_PULSE,
    parameter int SR_SETTLE = CAM_SR_SETTLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_hit,
    output logic             rsp_err,
    output logic             wlwr,
    output logic [WIDTH-1:0] dl,
    output logic [WIDTH-1:0] dlb,
    output logic             rbl_pre,
    output logic [WIDTH-1:0] rwl,
    input  logic             rbl_in,
    output logic [WIDTH-1:0] camdata,
    input  logic             match_in
);

    cam_state_e           state;
    cam_state_e           state_next;
    logic [CAM_CNT_W-1:0] cnt;
    logic [CAM_CNT_W-1:0] cnt_next;
    logic                 accept;
    logic                 seq_start;
    logic                 seq_done;
    logic [WIDTH-1:0]     seq_data;
`ifdef CAM_WR_VERIFY_EN
    logic [1:0]           op_q;
`endif

    assign accept = req_valid & req_ready;

    cam_rd_seq #(
        .WIDTH(WIDTH)
    ) u_rd_seq (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (seq_start),
        .rbl_in (rbl_in),
        .rbl_pre(rbl_pre),
        .rwl    (rwl),
        .done   (seq_done),
        .data   (seq_data)
    );

    // Next-state logic. The read states track the sequencer phase; the
    // sequencer itself owns the wordline/precharge strobes.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        seq_start  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (req_op)
                        OP_WR: state_next = ST_WR_SET;
                        OP_RD: begin
                            state_next = ST_RD_PRE;
                            seq_start  = 1'b1;
                        end
                        OP_SR: begin
                            state_next = ST_SR_DRV;
                            cnt_next   = '0;
                        end
                        default: state_next = ST_RESP;
                    endcase
                end
            end
            ST_WR_SET: begin
                state_next = ST_WR_PULSE;
                cnt_next   = '0;
            end
            ST_WR_PULSE: begin
                if (cnt == CAM_CNT_W'(WR_PULSE - 1)) begin
                    state_next = ST_WR_HOLD;
                end else begin
                    cnt_next = cnt + CAM_CNT_W'(1);
                end
            end
            ST_WR_HOLD: begin
`ifdef CAM_WR_VERIFY_EN
                state_next = ST_RD_PRE;
                seq_start  = 1'b1;
`else
                state_next = ST_RESP;
`endif
            end
            ST_RD_PRE:  state_next = ST_RD_EVAL;
            ST_RD_EVAL: state_next = seq_done ? ST_RESP : ST_RD_PRE;
            ST_SR_DRV: begin
                if (cnt == CAM_CNT_W'(SR_SETTLE - 1)) begin
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt + CAM_CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Registered outputs, decoded from the next state so every port comes
    // straight from a flop. Response fields only change on accept or on
    // entry to RESP, so they are stable while rsp_valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_hit   <= 1'b0;
            rsp_err   <= 1'b0;
            wlwr      <= 1'b0;
            dl        <= '0;
            dlb       <= '1;
            camdata   <= '0;
`ifdef CAM_WR_VERIFY_EN
            op_q      <= OP_WR;
`endif
        end else begin
            req_ready <= (state_next == ST_IDLE);
            rsp_valid <= (state_next == ST_RESP);
            wlwr      <= (state_next == ST_WR_PULSE);
            if (state == ST_IDLE && accept) begin
                rsp_data <= req_data;
                rsp_hit  <= 1'b0;
                rsp_err  <= (req_op == OP_ILL);
`ifdef CAM_WR_VERIFY_EN
                op_q     <= req_op;
`endif
                if (req_op == OP_WR) begin
                    dl  <= req_data;
                    dlb <= ~req_data;
                end
                if (req_op == OP_SR) begin
                    camdata <= req_data;
                end
            end
            if (state == ST_SR_DRV && state_next == ST_RESP) begin
                rsp_hit <= ~match_in;
            end
            if (state == ST_RD_EVAL && seq_done) begin
                rsp_data <= seq_data;
`ifdef CAM_WR_VERIFY_EN
                if (op_q == OP_WR) begin
                    rsp_err <= (seq_data != dl);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_cam_array_ctrl.sv
// tb_cam_array_ctrl
//   Directed bench for cam_array_ctrl with a behavioural model of one
//   CAM word: it stores dl while wlwr is high, returns the selected bit
//   on the read bitline (high while precharged) and raises match_in when
//   the key differs from the stored word.
module tb_cam_array_ctrl;
    import cam_pkg::*;

`ifdef CAM_WR_VERIFY_EN
    localparam int WR_LAT = 12;
`else
    localparam int WR_LAT = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [3:0] req_data = 4'h0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_data;
    logic       rsp_hit;
    logic       rsp_err;
    logic       wlwr;
    logic [3:0] dl;
    logic [3:0] dlb;
    logic       rbl_pre;
    logic [3:0] rwl;
    logic       rbl_in;
    logic [3:0] camdata;
    logic       match_in;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] stored = 4'h0;

    cam_array_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_data (req_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_hit  (rsp_hit),
        .rsp_err  (rsp_err),
        .wlwr     (wlwr),
        .dl       (dl),
        .dlb      (dlb),
        .rbl_pre  (rbl_pre),
        .rwl      (rwl),
        .rbl_in   (rbl_in),
        .camdata  (camdata),
        .match_in (match_in)
    );

    always #5 clk = ~clk;

    // Cell array model.
    always @(posedge clk) begin
        if (wlwr) stored <= dl;
    end
    assign rbl_in   = (rwl != 4'h0) ? |(rwl & stored) : 1'b1;
    assign match_in = |(camdata ^ stored);

    // Present a request at a falling edge; returns at the falling edge
    // after the accepting rising edge (observation point j=0).
    task automatic issue(input logic [1:0] op, input logic [3:0] data);
        req_op    = op;
        req_data  = data;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_req_ready got=%b exp=1", req_ready); end
        vectors++; if (wlwr !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_wlwr got=%b exp=0", wlwr); end
        vectors++; if (rwl !== 4'h0) begin miscompares++; $display("[TB] FAIL rst_rwl got=%h exp=0", rwl); end
        vectors++; if (rbl_pre !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_rbl_pre got=%b exp=0", rbl_pre); end
        vectors++; if (dlb !== 4'hF) begin miscompares++; $display("[TB] FAIL rst_dlb got=%h exp=F", dlb); end
        vectors++; if (dl !== 4'h0) begin miscompares++; $display("[TB] FAIL rst_dl got=%h exp=0", dl); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        vectors++; if (camdata !== 4'h0) begin miscompares++; $display("[TB] FAIL rst_camdata got=%h exp=0", camdata); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write(input logic [3:0] data, input logic [3:0] exp_dlb);
        int wl_cnt;
        int first_valid;
        wl_cnt      = 0;
        first_valid = -1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_ready_pre got=%b exp=1", req_ready); end
        issue(OP_WR, data);
        for (int j = 0; j <= WR_LAT; j++) begin
            if (j > 0) @(negedge clk);
            if (j == 0) begin
                vectors++; if (dl !== data) begin miscompares++; $display("[TB] FAIL wr_dl got=%h exp=%h", dl, data); end
                vectors++; if (dlb !== exp_dlb) begin miscompares++; $display("[TB] FAIL wr_dlb got=%h exp=%h", dlb, exp_dlb); end
                vectors++; if (wlwr !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_set_wlwr got=%b exp=0", wlwr); end
            end
            if (wlwr === 1'b1) begin
                wl_cnt++;
                vectors++; if (rwl !== 4'h0) begin miscompares++; $display("[TB] FAIL wr_rwl_overlap got=%h exp=0", rwl); end
            end
            if (rsp_valid === 1'b1 && first_valid < 0) first_valid = j;
        end
        vectors++; if (wl_cnt !== 2) begin miscompares++; $display("[TB] FAIL wr_pulse_len got=%0d exp=2", wl_cnt); end
        vectors++; if (first_valid !== WR_LAT) begin miscompares++; $display("[TB] FAIL wr_latency got=%0d exp=%0d", first_valid, WR_LAT); end
        vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_rsp_err got=%b exp=0", rsp_err); end
        vectors++; if (rsp_data !== data) begin miscompares++; $display("[TB] FAIL wr_rsp_data got=%h exp=%h", rsp_data, data); end
        consume();
        vectors++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_release got=%b/%b exp=0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_read(input logic [3:0] exp_data);
        logic [3:0] exp_rwl [8];
        exp_rwl = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8};
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_ready_pre got=%b exp=1", req_ready); end
        issue(OP_RD, 4'h0);
        for (int j = 0; j < 8; j++) begin
            if (j > 0) @(negedge clk);
            vectors++; if (rwl !== exp_rwl[j]) begin miscompares++; $display("[TB] FAIL rd_rwl j=%0d got=%h exp=%h", j, rwl, exp_rwl[j]); end
            vectors++; if (rbl_pre !== ((j % 2) == 0)) begin miscompares++; $display("[TB] FAIL rd_pre j=%0d got=%b", j, rbl_pre); end
            vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_early_valid j=%0d got=%b exp=0", j, rsp_valid); end
        end
        @(negedge clk);
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_valid got=%b exp=1", rsp_valid); end
        vectors++; if (rsp_data !== exp_data) begin miscompares++; $display("[TB] FAIL rd_data got=%h exp=%h", rsp_data, exp_data); end
        vectors++; if (rwl !== 4'h0 || rbl_pre !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_idle_strobes got=%h/%b exp=0/0", rwl, rbl_pre); end
        consume();
    endtask

    task automatic test_search(input logic [3:0] key, input logic exp_hit);
        issue(OP_SR, key);
        vectors++; if (camdata !== key) begin miscompares++; $display("[TB] FAIL sr_camdata got=%h exp=%h", camdata, key); end
        @(negedge clk);
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL sr_early_valid got=%b exp=0", rsp_valid); end
        @(negedge clk);
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL sr_valid got=%b exp=1", rsp_valid); end
        vectors++; if (rsp_hit !== exp_hit) begin miscompares++; $display("[TB] FAIL sr_hit key=%h got=%b exp=%b", key, rsp_hit, exp_hit); end
        vectors++; if (rsp_data !== key) begin miscompares++; $display("[TB] FAIL sr_data got=%h exp=%h", rsp_data, key); end
        consume();
        vectors++; if (camdata !== key) begin miscompares++; $display("[TB] FAIL sr_camdata_hold got=%h exp=%h", camdata, key); end
    endtask

    task automatic test_illegal_stall();
        issue(OP_ILL, 4'h6);
        for (int j = 0; j < 6; j++) begin
            if (j > 0) @(negedge clk);
            vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL ill_valid j=%0d got=%b exp=1", j, rsp_valid); end
            vectors++; if (rsp_err !== 1'b1) begin miscompares++; $display("[TB] FAIL ill_err j=%0d got=%b exp=1", j, rsp_err); end
            vectors++; if (rsp_data !== 4'h6 || rsp_hit !== 1'b0) begin miscompares++; $display("[TB] FAIL ill_rsp j=%0d got=%h/%b exp=6/0", j, rsp_data, rsp_hit); end
            vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL ill_ready j=%0d got=%b exp=0", j, req_ready); end
        end
        consume();
        vectors++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL ill_release got=%b/%b exp=0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_back_to_back();
        issue(OP_SR, 4'hA);
        repeat (2) @(negedge clk);
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_sr_valid got=%b exp=1", rsp_valid); end
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_op    = OP_RD;
        @(negedge clk);
        rsp_ready = 1'b0;
        vectors++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_release got=%b/%b exp=0/1", rsp_valid, req_ready); end
        vectors++; if (rbl_pre !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_no_accept got=%b exp=0", rbl_pre); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        vectors++; if (rbl_pre !== 1'b1 || req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_accept got=%b/%b exp=1/0", rbl_pre, req_ready); end
        repeat (8) @(negedge clk);
        vectors++; if (rsp_valid !== 1'b1 || rsp_data !== 4'hA) begin miscompares++; $display("[TB] FAIL b2b_rd got=%b/%h exp=1/A", rsp_valid, rsp_data); end
        consume();
    endtask

    task automatic test_reset_mid_read();
        int stray;
        stray = 0;
        issue(OP_RD, 4'h0);
        repeat (5) @(negedge clk);
        vectors++; if (rwl !== 4'h4) begin miscompares++; $display("[TB] FAIL mid_rwl_before got=%h exp=4", rwl); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (rwl !== 4'h0 || rbl_pre !== 1'b0 || wlwr !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_strobes got=%h/%b/%b exp=0/0/0", rwl, rbl_pre, wlwr); end
        vectors++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_handshake got=%b/%b exp=1/0", req_ready, rsp_valid); end
        vectors++; if (camdata !== 4'h0) begin miscompares++; $display("[TB] FAIL mid_camdata got=%h exp=0", camdata); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) stray++;
        end
        vectors++; if (stray !== 0) begin miscompares++; $display("[TB] FAIL mid_no_rsp got=%0d exp=0", stray); end
        test_write(4'h5, 4'hA);
        test_read(4'h5);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_write(4'hA, 4'h5);
        test_read(4'hA);
        test_search(4'hA, 1'b1);
        test_search(4'h3, 1'b0);
        test_illegal_stall();
        test_back_to_back();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
